// File: rtl/cache_arb_pkg.sv
// cache_arb_pkg: shared definitions for the two-requester cache arbiter.
//   - one-hot FSM state encoding
//   - address / data / timeout-counter widths and the default timeout
//   - the access descriptor latched at grant time
package cache_arb_pkg;

  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 8;
  localparam int CNT_W       = 8;
  localparam int TIMEOUT_DEF = 255;

  // Data returned to a requester when the cache never answers.
  localparam logic [DATA_W-1:0] ABORT_DATA = 8'hFF;

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    ISSUE = 3'b010,
    DONE  = 3'b100
  } state_t;

  // Everything the cache needs to perform one access.
  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant selection (purely combinational).
//   req0, req1 : requests from requester 0 and 1
//   last       : index of the requester granted most recently
//   grant      : index of the winning requester (meaningful only when any=1)
//   any        : at least one request is present
// With both requesting, the one not granted last wins; a lone requester
// always wins.
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant,
  output logic any
);

  always_comb begin
    // NOTE: every output gets a value on every path through this block;
    // leaving one unassigned on some path would infer a latch.
    grant = 1'b0;
    any   = req0 | req1;
    if (req0 && req1) grant = ~last;
    else if (req1)    grant = 1'b1;
  end

endmodule

// File: rtl/cache_arb.sv
// cache_arb: arbitrates two requesters onto a single direct-mapped cache port.
//
// Ports
//   clk, rstn               clock, asynchronous active-low reset
//   rN_req/rw/addr/wdata    requester N access request (level, held until ack)
//   rN_ack                  one-cycle pulse: request captured
//   rN_rdy                  one-cycle pulse: access complete
//   rN_rdata                read data for requester N, valid while rN_rdy=1
//   c_req/rw/addr/wdata     access presented to the cache
//   c_rdata, c_rdy          cache read data and completion pulse
//   busy                    FSM is not in IDLE
//   err                     sticky: an access was aborted on timeout
//
// Flow: IDLE grants one requester and latches its access into hold
// registers, ISSUE presents it to the cache until c_rdy or timeout, DONE
// is the single cycle in which rN_rdy is high.
module cache_arb
  import cache_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              r0_req,
  input  logic              r0_rw,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic              r0_rdy,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_rw,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic              r1_rdy,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              c_req,
  output logic              c_rw,
  output logic [ADDR_W-1:0] c_addr,
  output logic [DATA_W-1:0] c_wdata,
  input  logic [DATA_W-1:0] c_rdata,
  input  logic              c_rdy,
  output logic              busy,
  output logic              err
);

  // Counter value in the last ISSUE cycle before the access is aborted:
  // the TIMEOUT-th cycle without c_rdy ends the wait.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state;
  acc_t              hold;
  acc_t              pick;
  logic              owner;      // requester that owns the access in flight
  logic              last;       // round-robin pointer: last granted requester
  logic [CNT_W-1:0]  cnt;
  logic              arb_grant;
  logic              arb_any;
  logic              finish;
  logic [DATA_W-1:0] fin_data;

  rr_arb2 u_arb (
    .req0  (r0_req),
    .req1  (r1_req),
    .last  (last),
    .grant (arb_grant),
    .any   (arb_any)
  );

  // Access descriptor of whichever requester the arbiter picks this cycle.
  always_comb begin
    pick.rw    = arb_grant ? r1_rw    : r0_rw;
    pick.addr  = arb_grant ? r1_addr  : r0_addr;
    pick.wdata = arb_grant ? r1_wdata : r0_wdata;
  end

  // The access ends either on c_rdy or when the wait budget is used up;
  // c_rdy wins if both happen in the same cycle.
  assign finish   = c_rdy || (cnt == CNT_LAST);
  assign fin_data = c_rdy ? c_rdata : ABORT_DATA;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      hold     <= '0;
      owner    <= 1'b0;
      last     <= 1'b1;
      cnt      <= '0;
      err      <= 1'b0;
      r0_ack   <= 1'b0;
      r1_ack   <= 1'b0;
      r0_rdy   <= 1'b0;
      r1_rdy   <= 1'b0;
      r0_rdata <= '0;
      r1_rdata <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every
      // register here samples the pre-edge values of the others.
      r0_ack <= 1'b0;
      r1_ack <= 1'b0;
      r0_rdy <= 1'b0;
      r1_rdy <= 1'b0;

      unique case (state)
        IDLE: begin
          if (arb_any) begin
            owner <= arb_grant;
            last  <= arb_grant;
            hold  <= pick;
            cnt   <= '0;
            if (arb_grant) r1_ack <= 1'b1;
            else           r0_ack <= 1'b1;
            state <= ISSUE;
          end
        end

        ISSUE: begin
          if (finish) begin
            if (!c_rdy) err <= 1'b1;
            // Only the owner's outputs move; the other requester is untouched.
            if (owner) begin
              r1_rdy   <= 1'b1;
              r1_rdata <= fin_data;
            end else begin
              r0_rdy   <= 1'b1;
              r0_rdata <= fin_data;
            end
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

  // Dropping c_req as soon as c_rdy arrives keeps the cache from seeing a
  // request in the cycle it goes back to idle.
  assign c_req   = (state == ISSUE) && !c_rdy;
  assign c_rw    = hold.rw;
  assign c_addr  = hold.addr;
  assign c_wdata = hold.wdata;
  assign busy    = (state != IDLE);

endmodule
